// File: rtl/mul_div_unit.sv
// Iterative 32-step multiply/divide unit with private HI/LO registers.
// Shift-add multiply and restoring divide run on operand magnitudes; signs are applied in FIX.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hiWe,
  input  logic             loWe,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} stateT;

  stateT            state, nextState;
  logic [CW-1:0]    count;
  logic             opDiv;
  logic             negMain;
  logic             negRem;
  logic             divZero;
  logic [WIDTH-1:0] dividendRaw;
  logic [WIDTH-1:0] operand;
  logic [2*WIDTH-1:0] acc;

  logic             srcSigned;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH:0]   mulSum, remShift, remDiff;
  logic [2*WIDTH-1:0] accNext, prodFix;
  logic [WIDTH-1:0] quotFix, remFix;

  // Operand magnitudes; the most-negative value maps to itself, which is its correct unsigned magnitude.
  assign srcSigned = ~op[0];
  assign absA = (srcSigned && srcA[WIDTH-1]) ? -srcA : srcA;
  assign absB = (srcSigned && srcB[WIDTH-1]) ? -srcB : srcB;

  // acc = {partial product, remaining multiplier} or {partial remainder, dividend/quotient bits}.
  assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
  assign remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign remDiff  = remShift - {1'b0, operand};

  always_comb begin
    accNext = {mulSum, acc[WIDTH-1:1]};
    if (opDiv) begin
      if (remDiff[WIDTH]) accNext = {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else                accNext = {remDiff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    end
  end

  assign prodFix = negMain ? -acc : acc;
  assign quotFix = negMain ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign remFix  = negRem  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // NOTE: reset is synchronous here, so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = CALC;
      CALC:    if (count == CW'(WIDTH - 1)) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      count       <= '0;
      opDiv       <= 1'b0;
      negMain     <= 1'b0;
      negRem      <= 1'b0;
      divZero     <= 1'b0;
      dividendRaw <= '0;
      operand     <= '0;
      acc         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count       <= '0;
            opDiv       <= op[1];
            negMain     <= srcSigned && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
            negRem      <= srcSigned && srcA[WIDTH-1];
            divZero     <= op[1] && (srcB == '0);
            dividendRaw <= srcA;
            operand     <= op[1] ? absB : absA;
            acc         <= {{WIDTH{1'b0}}, (op[1] ? absA : absB)};
          end else begin
            if (hiWe) hi <= writeData;
            if (loWe) lo <= writeData;
          end
        end
        CALC: begin
          acc   <= accNext;
          count <= count + 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          if (!opDiv) begin
            hi <= prodFix[2*WIDTH-1:WIDTH];
            lo <= prodFix[WIDTH-1:0];
          end else if (divZero) begin
            hi <= dividendRaw;
            lo <= '1;
          end else begin
            hi <= remFix;
            lo <= quotFix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random operations against a plain-arithmetic model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA, srcB;
  logic        hiWe, loWe;
  logic [31:0] writeData;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .hiWe(hiWe), .loWe(loWe), .writeData(writeData),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} from plain signed/unsigned arithmetic.
  function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    case (o)
      2'd0: r = sa * sb;
      2'd1: r = {32'b0, a} * {32'b0, b};
      2'd2: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else        r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Issues one operation and checks latency, done pulse, HI/LO stability and the result.
  // With disturb set, hiWe/loWe accompany start and start/hiWe/loWe/operands are toggled while busy.
  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit disturb);
    logic [63:0] exp;
    logic [31:0] prevHi, prevLo;
    int n;
    bit finished;
    exp = refModel(o, a, b);
    prevHi = hi;
    prevLo = lo;
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    hiWe = disturb; loWe = disturb; writeData = ~prevHi;
    @(negedge clk);
    start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
    check({tag, " busyStart"}, {63'b0, busy}, 64'd1);
    n = 1;
    finished = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      n++;
      if (n == 5) check({tag, " hiloHeld"}, {hi, lo}, {prevHi, prevLo});
      if (disturb && n == 3) begin
        start = 1'b1; hiWe = 1'b1; loWe = 1'b1; writeData = 32'hDEAD_BEEF;
        op = ~o; srcA = ~a; srcB = b + 32'd1;
      end else begin
        start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
      end
    end
    check({tag, " finished"}, {63'b0, finished}, 64'd1);
    check({tag, " busyLen"}, 64'(n), 64'd33);
    check({tag, " donePulse"}, {63'b0, done}, 64'd1);
    check({tag, " result"}, {hi, lo}, exp);
    @(negedge clk);
    check({tag, " doneClear"}, {62'b0, done, busy}, 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; op = 2'd0; srcA = '0; srcB = '0;
    hiWe = 1'b0; loWe = 1'b0; writeData = '0;
    repeat (2) @(negedge clk);
    check("resetState", {30'b0, busy, done, hi}, 64'd0);
    check("resetLo", {32'b0, lo}, 64'd0);
    rst_n = 1'b1;

    runOp("multuMax", 2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("multuMaxConst", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    runOp("multNeg", 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check("multNegConst", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    runOp("multMinMin", 2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("multMinMinConst", {hi, lo}, 64'h4000_0000_0000_0000);
    runOp("divNeg", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("divNegConst", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp("divu100by7", 2'd3, 32'd100, 32'd7, 1'b0);
    check("divuConst", {hi, lo}, {32'd2, 32'd14});
    runOp("divuZero", 2'd3, 32'h1234, 32'd0, 1'b0);
    check("divuZeroConst", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
    runOp("divZero", 2'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
    runOp("divOvf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("divOvfConst", {hi, lo}, {32'd0, 32'h8000_0000});

    @(negedge clk);
    hiWe = 1'b1; writeData = 32'hD1;
    @(negedge clk);
    hiWe = 1'b0;
    check("mthi", {hi, lo}, {32'hD1, 32'h8000_0000});
    hiWe = 1'b1; loWe = 1'b1; writeData = 32'h55;
    @(negedge clk);
    hiWe = 1'b0; loWe = 1'b0;
    check("mthiMtloBoth", {hi, lo}, {32'h55, 32'h55});

    runOp("busyIgnore", 2'd1, 32'd3, 32'd4, 1'b1);
    check("busyIgnoreConst", {hi, lo}, {32'd0, 32'd12});

    @(negedge clk);
    start = 1'b1; op = 2'd3; srcA = 32'd1000; srcB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midReset", {30'b0, busy, done, hi}, 64'd0);
    check("midResetLo", {32'b0, lo}, 64'd0);
    rst_n = 1'b1;
    runOp("afterReset", 2'd1, 32'd6, 32'd7, 1'b0);
    check("afterResetConst", {hi, lo}, {32'd0, 32'd42});

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      runOp($sformatf("rand%0d", i), ro, ra, rb, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
